// File: rtl/io_fabric.sv
// io_fabric: I/O bus fabric for the platform top level.
//   Decodes a 64-word I/O window into per-device strobes. It returns the
//   selected device's read data and ack to the CPU. It terminates unmapped
//   accesses, and (optionally) accesses to hung devices, with a one-cycle
//   fabric response. Each error is logged in a status register at STAT_ADDR.
//
// Optional feature macro: IO_FABRIC_TIMEOUT_EN
//   When defined, a 16-bit wait counter terminates mapped accesses that stay
//   unacked for TIMEOUT cycles (cause 1). When undefined, there is no counter
//   and a non-acking device stalls the bus.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   stb, we      I/O strobe (held until ack) and write enable
//   addr         word address bus_addr[7:2]
//   data_out     read data to the bus
//   ack          transfer complete
//   dev_stb      per-slot strobe (one-hot or zero)
//   dev_dout     per-slot read data, slot i at [32*i+31:32*i]
//   dev_ack      per-slot ack
//   err_trig     one-cycle pulse per logged error
//
// Status register:
//   bit31 valid, bit30 cause, bit29 we, [23:16] saturating error count,
//   [5:0] faulting word address. A write of any data clears it.
module io_fabric #(
  parameter int unsigned          NUM_DEV   = 12,
  parameter logic [6*NUM_DEV-1:0] DEV_BASE  = '0,
  parameter logic [6*NUM_DEV-1:0] DEV_MASK  = '1,
  parameter logic [5:0]           STAT_ADDR = 6'b010000,
  parameter int unsigned          TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stb,
  input  logic                    we,
  input  logic [5:0]              addr,
  output logic [31:0]             data_out,
  output logic                    ack,
  output logic [NUM_DEV-1:0]      dev_stb,
  input  logic [32*NUM_DEV-1:0]   dev_dout,
  input  logic [NUM_DEV-1:0]      dev_ack,
  output logic                    err_trig
);

  if (NUM_DEV < 1 || NUM_DEV > 32 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
    $error("io_fabric: parameter out of range");
  end

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state, state_nx;
  logic [31:0]        status;
  logic               resp_rd;
  logic               resp_err;
  logic [NUM_DEV-1:0] win;
  logic               any_hit;
  logic [31:0]        sel_data;
  logic               sel_ack;
  logic               stat_hit;
  logic               in_idle;
  logic               mapped;
  logic               req_stat;
  logic               req_unmap;
  logic               to_hit;

  // Priority decode: the lowest-index hit wins, so win is one-hot or zero.
  always_comb begin
    win     = '0;
    any_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (!any_hit &&
          ((addr & DEV_MASK[6*i +: 6]) == (DEV_BASE[6*i +: 6] & DEV_MASK[6*i +: 6]))) begin
        any_hit = 1'b1;
        win[i]  = 1'b1;
      end
    end
  end

  // AND-OR mux over the one-hot select.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (win[i]) sel_data = sel_data | dev_dout[32*i +: 32];
    end
  end

  assign sel_ack   = |(win & dev_ack);
  assign stat_hit  = (addr == STAT_ADDR);
  assign in_idle   = (state == IDLE);
  assign mapped    = in_idle & stb & ~stat_hit & any_hit;
  assign req_stat  = in_idle & stb & stat_hit;
  assign req_unmap = in_idle & stb & ~stat_hit & ~any_hit;

`ifdef IO_FABRIC_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // A device ack in the same cycle as the final count wins over the timeout.
  assign to_hit = mapped & ~sel_ack & (wait_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_idle || !stb || ack) begin
      wait_cnt <= '0;
    end else if (mapped) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    data_out = '0;
    dev_stb  = '0;
    unique case (state)
      IDLE: begin
        if (mapped) begin
          dev_stb  = win;
          data_out = sel_data;
          ack      = sel_ack;
        end
        if (req_stat || req_unmap || to_hit) state_nx = RESP;
      end
      RESP: begin
        ack      = 1'b1;
        data_out = resp_rd ? status : '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign err_trig = (state == RESP) & resp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      status   <= '0;
      resp_rd  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (in_idle) begin
        resp_rd  <= req_stat & ~we;
        resp_err <= req_unmap | to_hit;
        if (req_stat && we) begin
          status <= '0;
        end else if (req_unmap || to_hit) begin
          status <= {1'b1, to_hit, we, 5'b0,
                     (status[23:16] == 8'hFF) ? 8'hFF : status[23:16] + 8'd1,
                     10'b0, addr};
        end
      end
    end
  end

endmodule

// File: tb/tb_io_fabric.sv
// Self-checking bench for io_fabric with two slots:
// slot0 at 6'b110000 (exact match) and slot1 at 6'b11001x.
// Every access pushes its expected response to a scoreboard queue. The
// response is popped and compared when the fabric acks, or when the wait
// bound expires.
module tb_io_fabric;

  localparam logic [5:0] STAT = 6'b010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] data_out;
  logic        ack;
  logic [1:0]  dev_stb;
  logic [63:0] dev_dout;
  logic [1:0]  dev_ack;
  logic        err_trig;

  always #5 clk = ~clk;

  io_fabric #(
    .NUM_DEV  (2),
    .DEV_BASE (12'b110010_110000),
    .DEV_MASK (12'b111110_111111),
    .STAT_ADDR(STAT),
    .TIMEOUT  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stb     (stb),
    .we      (we),
    .addr    (addr),
    .data_out(data_out),
    .ack     (ack),
    .dev_stb (dev_stb),
    .dev_dout(dev_dout),
    .dev_ack (dev_ack),
    .err_trig(err_trig)
  );

  // Device model: slot i acks once its strobe has been high for lat[i] cycles.
  int unsigned lat [2];
  int unsigned wcnt[2];
  logic [31:0] ddata[2];

  assign dev_dout   = {ddata[1], ddata[0]};
  assign dev_ack[0] = dev_stb[0] && (wcnt[0] == lat[0]);
  assign dev_ack[1] = dev_stb[1] && (wcnt[1] == lat[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !dev_stb[i] || dev_ack[i]) wcnt[i] <= 0;
      else                                  wcnt[i] <= wcnt[i] + 1;
    end
  end

  typedef struct {
    logic        a;   // ack seen within the bound
    logic [31:0] d;   // data_out with ack
    int unsigned l;   // ack latency in cycles, stb-high cycle 1 = 1
    logic        e;   // err_trig with ack
    logic [1:0]  s;   // dev_stb in the first cycle
  } resp_t;

  resp_t       exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic [5:0] a, input logic w,
                        input int unsigned limit, input resp_t e);
    resp_t       ex;
    logic        got_a = 1'b0;
    logic [31:0] got_d = '0;
    int unsigned got_l = 0;
    logic        got_e = 1'b0;
    logic [1:0]  got_s = '0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    stb = 1'b1; addr = a; we = w;
    for (int unsigned c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) got_s = dev_stb;
      if (ack) begin
        got_a = 1'b1; got_d = data_out; got_l = c; got_e = err_trig;
        break;
      end
    end
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    ex = exp_q.pop_front();
    check({tag, ".ack"},  32'(got_a), 32'(ex.a));
    check({tag, ".data"}, got_d,      ex.d);
    check({tag, ".lat"},  32'(got_l), 32'(ex.l));
    check({tag, ".err"},  32'(got_e), 32'(ex.e));
    check({tag, ".stb"},  32'(got_s), 32'(ex.s));
  endtask

  task automatic stat_read(input string tag, input logic [31:0] v);
    access(tag, STAT, 1'b0, 4, '{1'b1, v, 2, 1'b0, 2'b00});
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0;
    lat[0] = 255; lat[1] = 255;
    ddata[0] = 32'hCAFEF00D; ddata[1] = 32'h12345678;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ack",      32'(ack),      32'd0);
    check("rst.dev_stb",  32'(dev_stb),  32'd0);
    check("rst.err_trig", 32'(err_trig), 32'd0);
    check("rst.data_out", data_out,      32'd0);
    @(posedge clk); #1 rst = 1'b0;
    stat_read("rst.status", 32'h0);

    // Mapped accesses: slot1 via masked compare, slot0 exact
    lat[1] = 2;
    access("map1_rd", 6'b110011, 1'b0, 20, '{1'b1, 32'h12345678, 3, 1'b0, 2'b10});
    access("map1_wr", 6'b110010, 1'b1, 20, '{1'b1, 32'h12345678, 3, 1'b0, 2'b10});
    lat[0] = 0;
    access("map0_rd", 6'b110000, 1'b0, 20, '{1'b1, 32'hCAFEF00D, 1, 1'b0, 2'b01});
    stat_read("map.status", 32'h0);

    // Unmapped neighbour of slot0 (exact mask)
    access("unmap_nb", 6'b110001, 1'b0, 4, '{1'b1, 32'h0, 2, 1'b1, 2'b00});
    stat_read("unmap_nb.status", 32'h80010031);
    access("stat_wr", STAT, 1'b1, 4, '{1'b1, 32'h0, 2, 1'b0, 2'b00});
    stat_read("clr.status", 32'h0);

    // Unmapped write
    access("unmap_wr", 6'b000001, 1'b1, 4, '{1'b1, 32'h0, 2, 1'b1, 2'b00});
    stat_read("unmap_wr.status", 32'hA0010001);
    access("stat_wr2", STAT, 1'b1, 4, '{1'b1, 32'h0, 2, 1'b0, 2'b00});

    // Hung slot0
    lat[0] = 255;
`ifdef IO_FABRIC_TIMEOUT_EN
    access("timeout", 6'b110000, 1'b0, 12, '{1'b1, 32'h0, 9, 1'b1, 2'b01});
    stat_read("timeout.status", 32'hC0010030);
    access("stat_wr3", STAT, 1'b1, 4, '{1'b1, 32'h0, 2, 1'b0, 2'b00});
`else
    access("stall", 6'b110000, 1'b0, 20, '{1'b0, 32'h0, 0, 1'b0, 2'b01});
`endif
    stat_read("hung.status_clr", 32'h0);

    // Device ack in the final counter cycle beats the timeout
    lat[0] = 7; ddata[0] = 32'h5A5A1234;
    access("race", 6'b110000, 1'b0, 12, '{1'b1, 32'h5A5A1234, 8, 1'b0, 2'b01});
    stat_read("race.status", 32'h0);

    // Count saturation
    for (int k = 0; k < 260; k++)
      access("unmap_sat", 6'b000010, 1'b0, 4, '{1'b1, 32'h0, 2, 1'b1, 2'b00});
    stat_read("sat.status", 32'h80FF0002);

    // Reset during RESP
    @(posedge clk); #1;
    stb = 1'b1; addr = 6'b000001; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_resp.ack_pre", 32'(ack), 32'd1);
    rst = 1'b1; stb = 1'b0;
    @(negedge clk);
    check("rst_resp.ack",      32'(ack),      32'd0);
    check("rst_resp.err_trig", 32'(err_trig), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    stat_read("rst_resp.status", 32'h0);

    // Write clears after a fresh error
    access("unmap_last", 6'b111111, 1'b0, 4, '{1'b1, 32'h0, 2, 1'b1, 2'b00});
    stat_read("last.status", 32'h8001003F);
    access("stat_wr4", STAT, 1'b1, 4, '{1'b1, 32'h0, 2, 1'b0, 2'b00});
    stat_read("final.status", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
